// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = 20;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Bit period minus one for a given clock and line rate.
  function automatic logic [UART_CNT_W-1:0] skip_default(input int unsigned clk_hz,
                                                         input int unsigned baud);
    return UART_CNT_W'(clk_hz / baud - 1);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is configurable.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-cycle byte strobe and frame-error pulse.
// Optional 64-bit word packing is compiled in with `define UART_RX_WORD_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clock_speed = 100_000_000,
  parameter int unsigned baud_rate   = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic [UART_CNT_W-1:0]     skipcycles,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  output logic                      frame_err,
`ifdef UART_RX_WORD_EN
  input  logic                      endianness,
  output logic [63:0]               word,
  output logic                      word_valid,
`endif
  output logic                      busy
);

  localparam logic [UART_CNT_W-1:0] SKIP_DEFAULT = skip_default(clock_speed, baud_rate);

  logic                      rx_s;
  uart_rx_state_t            state, state_d;
  logic [UART_CNT_W-1:0]     cnt, cnt_d, skip_eff, half;
  logic [2:0]                idx, idx_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d, data_d;
  logic                      data_valid_d, frame_err_d;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Out-of-range periods fall back to the parameter-derived rate.
  assign skip_eff = (skipcycles < UART_CNT_W'(3)) ? SKIP_DEFAULT : skipcycles;
  assign half     = skip_eff >> 1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shift      <= shift_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + UART_CNT_W'(1);
    idx_d        = idx;
    shift_d      = shift;
    data_d       = data;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == half) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == skip_eff) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          idx_d        = idx + 3'd1;
          if (idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == skip_eff) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d       = shift;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_WORD_EN
  logic [2:0]  bcnt, lane;
  logic        endian_l, endian_eff;
  logic [63:0] acc, acc_next;

  // Bytes build up in acc so word only ever shows a completed word.
  assign endian_eff = (bcnt == 3'd0) ? endianness : endian_l;
  assign lane       = endian_eff ? (3'd7 - bcnt) : bcnt;

  always_comb begin
    acc_next = acc;
    acc_next[{lane, 3'b000} +: 8] = shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      endian_l   <= 1'b0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (data_valid_d) begin
        acc  <= acc_next;
        bcnt <= bcnt + 3'd1;
        if (bcnt == 3'd0) endian_l <= endianness;
        if (bcnt == 3'd7) begin
          word       <= acc_next;
          word_valid <= 1'b1;
        end
      end else if (frame_err_d) begin
        bcnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases and a randomized run.
module tb_uart_rx;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [19:0] skipcycles = 20'd15;
  logic [7:0]  data;
  logic        data_valid, frame_err, busy;
`ifdef UART_RX_WORD_EN
  logic        endianness = 1'b0;
  logic [63:0] word;
  logic        word_valid;
`endif

  uart_rx #(.clock_speed(100_000_000), .baud_rate(115200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .skipcycles (skipcycles),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_WORD_EN
    .endianness (endianness),
    .word       (word),
    .word_valid (word_valid),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Monitor: collects every pulse seen on the outputs.
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned last_dv_cyc = 0;
  int          fe_count = 0;
  logic [7:0]  got_bytes[$];
  logic [63:0] got_words[$];
  logic        prev_dv = 1'b0, prev_fe = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      got_bytes.push_back(data);
      last_dv_cyc = cyc;
    end
    if (frame_err) fe_count++;
    if (data_valid || frame_err) begin
      check("dv_fe_exclusive", 64'(data_valid & frame_err), 64'd0);
      check("pulse_one_cycle", 64'((data_valid & prev_dv) | (frame_err & prev_fe)), 64'd0);
    end
`ifdef UART_RX_WORD_EN
    if (word_valid) begin
      got_words.push_back(word);
      check("word_valid_with_dv", 64'(data_valid), 64'd1);
    end
`endif
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  task automatic clear_events();
    got_bytes.delete();
    got_words.delete();
    fe_count = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_bits);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    if (!stop) repeat (hold_bits * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         hold;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, diff, busy_cycles;
    logic [7:0]  exp_bytes[$];
    int          exp_fe;
    logic [7:0]  last_good;

    vecs[0] = '{8'h55, 1'b1, 0,  1, 0, 8'h55};
    vecs[1] = '{8'hA5, 1'b0, 40, 0, 1, 8'h55};
    vecs[2] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C};
    vecs[3] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 2,  0, 1, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
    vecs[6] = '{8'h80, 1'b1, 0,  1, 0, 8'h80};

    repeat (3) @(negedge clk);
    #1;
    check("reset_data", 64'(data), 64'd0);
    check("reset_dv", 64'(data_valid), 64'd0);
    check("reset_fe", 64'(frame_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
`ifdef UART_RX_WORD_EN
    check("reset_word", word, 64'd0);
    check("reset_word_valid", 64'(word_valid), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[v]) begin
      clear_events();
      send_frame(vecs[v].b, vecs[v].stop, vecs[v].hold);
      check($sformatf("vec%0d_dv_count", v), 64'(got_bytes.size()), 64'(vecs[v].exp_dv));
      check($sformatf("vec%0d_fe_count", v), 64'(fe_count), 64'(vecs[v].exp_fe));
      check($sformatf("vec%0d_data", v), 64'(data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_busy_idle", v), 64'(busy), 64'd0);
      if (vecs[v].exp_dv == 1 && got_bytes.size() == 1)
        check($sformatf("vec%0d_byte", v), 64'(got_bytes[0]), 64'(vecs[v].b));
      if (v == 0) begin
        lat  = last_dv_cyc - start_cyc;
        diff = (lat > 155) ? lat - 155 : 155 - lat;
        n_checks++;
        if (diff > 1) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, expected 155 +/- 1", lat);
        end
      end
    end

    // Short low glitch must be rejected at mid-start.
    clear_events();
    busy_cycles = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles > 8 || busy_cycles == 0) begin
      n_fail++;
      $display("FAIL glitch_busy: got %0d busy cycles, expected 1..8", busy_cycles);
    end
    check("glitch_no_dv", 64'(got_bytes.size()), 64'd0);
    check("glitch_no_fe", 64'(fe_count), 64'd0);

`ifdef UART_RX_WORD_EN
    do_reset();
    clear_events();
    endianness = 1'b0;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 0);
    check("word_le_count", 64'(got_words.size()), 64'd1);
    check("word_le_value", word, 64'h0807060504030201);
    check("word_le_coincident", 64'(last_dv_cyc == cyc || got_words.size() == 1), 64'd1);

    do_reset();
    clear_events();
    endianness = 1'b1;
    for (int i = 1; i <= 3; i++) send_frame(8'(i), 1'b1, 0);
    endianness = 1'b0;
    for (int i = 4; i <= 8; i++) send_frame(8'(i), 1'b1, 0);
    check("word_be_count", 64'(got_words.size()), 64'd1);
    check("word_be_value", word, 64'h0102030405060708);
`endif

    // Reset asserted mid-byte, during bit 4.
    do_reset();
    send_frame(8'h5A, 1'b1, 0);
`ifdef UART_RX_WORD_EN
    endianness = 1'b0;
    send_frame(8'h99, 1'b1, 0);
`endif
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'hC3 >> i) & 8'h01) != 8'h00;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_data", 64'(data), 64'd0);
    check("midreset_dv", 64'(data_valid), 64'd0);
    check("midreset_fe", 64'(frame_err), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
`ifdef UART_RX_WORD_EN
    check("midreset_word", word, 64'd0);
`endif
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_events();
    send_frame(8'hC3, 1'b1, 0);
    check("post_reset_count", 64'(got_bytes.size()), 64'd1);
    check("post_reset_data", 64'(data), 64'hC3);
`ifdef UART_RX_WORD_EN
    for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b1, 0);
    check("post_reset_word_count", 64'(got_words.size()), 64'd1);
    check("post_reset_word", word, 64'h07060504030201C3);
`endif

    // Randomized frames against a reference of expected events.
    do_reset();
    clear_events();
    exp_bytes.delete();
    exp_fe = 0;
    last_good = 8'h00;
    begin
      logic [63:0] exp_words[$];
      logic [63:0] m_acc;
      int          m_cnt;
      logic        m_end;
      m_acc = '0;
      m_cnt = 0;
      m_end = 1'b0;
      for (int n = 0; n < 24; n++) begin
        logic [7:0] b;
        logic       stop;
        int         hold;
        b    = 8'($urandom);
        stop = ($urandom_range(0, 7) != 0);
        hold = int'($urandom_range(0, 5));
`ifdef UART_RX_WORD_EN
        endianness = 1'($urandom_range(0, 1));
`endif
        if (stop) begin
          exp_bytes.push_back(b);
          last_good = b;
`ifdef UART_RX_WORD_EN
          if (m_cnt == 0) m_end = endianness;
          m_acc[(m_end ? 7 - m_cnt : m_cnt) * 8 +: 8] = b;
          if (m_cnt == 7) exp_words.push_back(m_acc);
          m_cnt = (m_cnt + 1) % 8;
`endif
        end else begin
          exp_fe++;
          m_cnt = 0;
        end
        send_frame(b, stop, hold);
      end
      check("rand_dv_count", 64'(got_bytes.size()), 64'(exp_bytes.size()));
      check("rand_fe_count", 64'(fe_count), 64'(exp_fe));
      foreach (exp_bytes[i])
        if (i < got_bytes.size())
          check($sformatf("rand_byte%0d", i), 64'(got_bytes[i]), 64'(exp_bytes[i]));
      check("rand_final_data", 64'(data), 64'(last_good));
`ifdef UART_RX_WORD_EN
      check("rand_word_count", 64'(got_words.size()), 64'(exp_words.size()));
      foreach (exp_words[i])
        if (i < got_words.size())
          check($sformatf("rand_word%0d", i), got_words[i], exp_words[i]);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the team's `uart_tx`. It takes the asynchronous `rx` line, recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit), and presents each byte with a one-cycle valid strobe. With the word feature compiled in, it also packs 8 consecutive bytes into a 64-bit word, in either byte order, for the host-side buffer logic.

## Interface
Parameters:
- `clock_speed`, 100_000_000: system clock frequency in Hz; used only for documentation and the `skipcycles` reset default.
- `baud_rate`, 115200: nominal line rate; used only for documentation and the `skipcycles` reset default.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `rx`  input  1  asynchronous serial line; idles high.
- `skipcycles`  input  20  bit period minus one, in clk cycles (clock_speed/baud_rate-1); valid range ≥ 3; may change only while `busy`=0.
- `data`  output  8  last correctly framed byte.
- `data_valid`  output  1  one-cycle pulse; `data` updated in the same cycle.
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low.
- `busy`  output  1  high in every state except IDLE.
- `endianness`  input  1  1: big, 0: little (UART_RX_WORD_EN only).
- `word`  output  64  assembled word (UART_RX_WORD_EN only).
- `word_valid`  output  1  one-cycle pulse (UART_RX_WORD_EN only).

## Operation
- `rx` passes through a 2-FF synchronizer; the synchronizer resets to 1. All decisions below use the synchronized signal `rx_s`.
- Internal counters: bit counter `cnt` (20 bits) and bit index `idx` (3 bits).
- State machine:
  - IDLE: when `rx_s`=0, go to START with `cnt`=0.
  - START: when `cnt`==`skipcycles`>>1 (mid-bit): if `rx_s`=0, go to DATA with `cnt`=0 and `idx`=0; otherwise go back to IDLE (glitch rejected, nothing reported).
  - DATA: when `cnt`==`skipcycles`, sample `rx_s` into shift bit `idx`, reset `cnt` to 0 and increment `idx`. After `idx`=7 is sampled, go to STOP.
  - STOP: when `cnt`==`skipcycles`:
    - `rx_s`=1: load `data`, pulse `data_valid`, go to IDLE.
    - `rx_s`=0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A line held low never produces a spurious frame.
- Because STOP completes at mid-stop-bit, the receiver re-arms half a bit early and tolerates about ±4% clock mismatch.
- Shift register holds bit `idx` at position `idx`, so the first received bit is `data[0]`.

## Timing
- Reset values: `data`=0, `data_valid`=0, `frame_err`=0, `busy`=0, `word`=0, `word_valid`=0, state IDLE, all counters 0.
- Latency from the first low `rx` edge to the `data_valid` edge is 2 + (`skipcycles`>>1)+1 + 9·(`skipcycles`+1) + 1 cycles, ±1 for synchronizer phase.
- `data_valid` and `frame_err` are never asserted together, and each is high for exactly one cycle.
- Asserting reset mid-frame aborts the frame and discards the partial byte and partial word. After release the block is in IDLE; if `rx` is low at that point, it is treated as a start bit.

## Configuration
- Macro `UART_RX_WORD_EN` defined:
  - A 3-bit byte counter `bcnt` and the `word`, `word_valid` and `endianness` ports exist.
  - On each `data_valid`, byte k = `bcnt` is written to `word[8k+7:8k]` when little-endian, or to `word[63-8k:56-8k]` when big-endian.
  - `endianness` is latched when `bcnt`=0 and held for the rest of that word.
  - When `bcnt`=7, `word_valid` pulses in the same cycle as `data_valid` and `bcnt` wraps to 0.
  - `frame_err` clears `bcnt` to 0; the partial word is discarded and `word` keeps its last complete value.
- Macro not defined: the three ports and all associated logic are absent; byte path only.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS`=8;
  - `UART_CNT_W`=20.
- Sub-module `uart_sync2`: 2-FF synchronizer with a reset value parameter, reusable for other asynchronous inputs.

## Test plan
- `skipcycles`=15, send 0x55 → exactly one `data_valid`, `data`=0x55, `frame_err` never asserted, `busy` back to 0.
- `rx` low for 3 cycles then high, `skipcycles`=15 → no `data_valid`, no `frame_err`; `busy` high for at most 8 cycles.
- Send 0xA5 with stop bit 0, then hold `rx` low for 40 bit times → one `frame_err`; `data` keeps its previous value; no further pulses until `rx` goes high; the next valid byte 0x3C is received correctly.
- `UART_RX_WORD_EN`, `endianness`=0, send 0x01..0x08 → single `word_valid` coincident with the 8th `data_valid`; `word`=0x0807060504030201.
- `UART_RX_WORD_EN`, `endianness`=1, same bytes, with `endianness` toggled after byte 3 → `word`=0x0102030405060708.
- Assert `rst_n` low during bit 4 of a byte → all outputs go to their reset values asynchronously; after release, 0xC3 is received correctly and `bcnt` starts at 0.
